// File: rtl/mips_cpu_pkg.sv
// Shared CPU decode types for the multiply/divide unit: opcode enum, FSM states,
// and op-class helpers used by both the unit and the control path.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        OpNop   = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMfhi  = 4'd7,
        OpMflo  = 4'd8
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } muldiv_state_t;

    // True for ops that start a multi-cycle iteration.
    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    endfunction

    function automatic logic is_hilo_op(input logic [3:0] op);
        return (op == OpMthi) || (op == OpMtlo) || (op == OpMfhi) || (op == OpMflo);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add for multiply,
// restoring trial-subtract for divide (lower half collects quotient bits).
module mips_cpu_muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             ge;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        // Extra top bit of diff is the borrow: clear means the divisor fits.
        diff   = {1'b0, rem_sh} - {2'b00, operand_i};
        ge     = ~diff[WIDTH+1];
        if (is_div_i) begin
            acc_o = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv_iter.sv
// Iterative multiply/divide unit owning HI/LO. Operates on magnitudes during RUN and
// applies sign correction in FIX, so the step chain is purely unsigned.
module mips_cpu_muldiv_iter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned Steps = WIDTH / UNROLL;
    localparam int unsigned CntW  = $clog2(Steps + 1);

    if (WIDTH % UNROLL != 0) begin : g_bad_unroll
        $error("UNROLL must divide WIDTH");
    end

    muldiv_state_t      state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic               sa_q, sa_d, sb_q, sb_d, is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dz_q, dz_d;

    muldiv_op_t         op_e;
    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b, step_operand, quot, rem;
    logic [2*WIDTH-1:0] prod;
    logic [UNROLL:0][2*WIDTH-1:0] chain;

    assign op_e         = muldiv_op_t'(op);
    assign step_operand = is_div_q ? opb_q : opa_q;
    assign chain[0]     = acc_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
            .acc_i    (chain[i]),
            .operand_i(step_operand),
            .is_div_i (is_div_q),
            .acc_o    (chain[i+1])
        );
    end

    always_comb begin
        signed_op = (op_e == OpMult) || (op_e == OpDiv);
        mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
        prod      = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot      = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid) begin
                        if (is_muldiv_op(op)) begin
                            state_d  = StRun;
                            cnt_d    = CntW'(Steps);
                            opa_d    = mag_a;
                            opb_d    = mag_b;
                            sa_d     = signed_op & a[WIDTH-1];
                            sb_d     = signed_op & b[WIDTH-1];
                            is_div_d = (op_e == OpDiv) || (op_e == OpDivu);
                            acc_d    = {{WIDTH{1'b0}}, (is_div_d ? mag_a : mag_b)};
                        end else if (op_e == OpMthi) begin
                            hi_d = a;
                        end else if (op_e == OpMtlo) begin
                            lo_d = a;
                        end
                    end
                end
                StRun: begin
                    acc_d = chain[UNROLL];
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod;
                    end else if (opb_q == '0) begin
                        hi_d = sa_q ? -opa_q : opa_q;
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        op_ready = (state_q == StIdle);
        stall    = op_valid && (is_muldiv_op(op) || is_hilo_op(op)) && !op_ready;
        done     = done_q;
        div_zero = dz_q;
        if (op_e == OpMfhi) begin
            result = hi_q;
        end else if (op_e == OpMflo) begin
            result = lo_q;
        end else begin
            result = '0;
        end
    end

endmodule
